grf_write_arbiter: RTL and testbench
====================================

# grf_write_arbiter

Write-port arbiter in front of the general register file. Merges two write sources onto the single GRF write port: the in-order pipeline writeback (highest priority, never stalled) and a long-latency secondary source (multiply/divide or memory unit) with a valid/ready handshake. Secondary writes are buffered in a small queue and drained in cycles where the pipeline does not write. Older queued writes are squashed when the pipeline overwrites the same register. Outputs drive the GRF's RegWr/A3/WD/now_pc inputs directly.

## Interface
- DEPTH, 4, secondary queue entries; power of two, 2..16
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- p_we  in  1  pipeline write request this cycle
- p_addr  in  5  pipeline destination register
- p_data  in  32  pipeline write data
- p_pc  in  32  PC of the pipeline instruction
- s_valid  in  1  secondary write offered
- s_ready  out  1  secondary write can be accepted
- s_addr  in  5  secondary destination register
- s_data  in  32  secondary write data
- s_pc  in  32  PC of the secondary instruction
- q_addr  in  5  hazard query register number
- q_hit  out  1  combinational: a valid queued entry targets q_addr (always 0 when q_addr is 0)
- count  out  $clog2(DEPTH)+1  queued entries, valid and squashed
- RegWr  out  1  registered GRF write enable
- A3  out  5  registered GRF write address
- WD  out  32  registered GRF write data
- now_pc  out  32  registered PC for the write trace

## Operation
- Queue: circular FIFO of DEPTH entries {valid, addr, data, pc}, with read/write pointers and count.
- Secondary accept: handshake when s_valid && s_ready. s_ready = !reset && (count < DEPTH), from registered count. A pop in the same cycle does not free space for that cycle's push.
- Writes with addr 0 from either source are discarded:
  - p_we with p_addr == 0 is treated as no pipeline write.
  - A secondary handshake with s_addr == 0 completes but does not enqueue.
- Output selection each cycle, registered on the next edge:
  - If pipeline writes (p_we && p_addr != 0): RegWr=1, A3/WD/now_pc = p_addr/p_data/p_pc. No pop.
  - Else, if count > 0: pop the head. RegWr = head.valid, with A3/WD/now_pc = head fields. A squashed head pops with RegWr=0.
  - Else: RegWr=0. A3/WD/now_pc hold their previous values.
- Squash: an accepted pipeline write to X clears valid on every queued entry with addr X that was present before this edge. A secondary entry enqueued in the same cycle is younger and is not squashed.
- Simultaneous push and pop: both take effect, and count is unchanged.

## Timing
- Pipeline write: RegWr/A3/WD visible 1 cycle after p_we is sampled.
- Secondary write: earliest visible 2 cycles after the handshake (enqueue at edge N, pop at edge N+1). It is delayed 1 cycle per intervening pipeline write.
- Queue drain rate: one entry per non-pipeline-write cycle.
- Reset values: RegWr=0, A3=0, WD=0, now_pc=0, count=0, all valid=0, pointers=0.
- s_ready=0 while reset is asserted and 1 on the first cycle after.
- Reset mid-operation: all queued entries are dropped with no write issued. Handshakes and p_we in the reset cycle are ignored.
- q_hit is combinational from q_addr and queue state; it reflects the state before the current edge.

## Test plan
- Reset, then p_we=1, p_addr=5, p_data=0x1234, p_pc=0x3000 for 1 cycle -> next cycle RegWr=1, A3=5, WD=0x1234, now_pc=0x3000; the cycle after, RegWr=0.
- Idle pipeline, secondary s_addr=8, s_data=0xAAAA accepted at cycle N -> RegWr=1, A3=8 at cycle N+2. count goes 1 then 0.
- With DEPTH=4, offer 5 secondary writes while p_we is held high with addr 3 -> s_ready drops after 4 accepts and count=4. After p_we deasserts, 4 writes drain on consecutive cycles in FIFO order.
- Queue an s_addr=9 entry, then pipeline writes reg 9 -> q_hit(9) goes 1 then 0. The pipeline write appears, and the squashed pop later gives RegWr=0 in its slot. Register 9 is never written with the secondary data.
- Pipeline writes reg 10 in the same cycle a secondary entry for reg 10 is accepted -> the pipeline write issues first and the secondary write issues later (not squashed).
- Writes to reg 0 from both sources -> RegWr never asserts and count stays 0. Then assert reset with 3 entries queued -> count=0, RegWr=0, and no queued write ever appears.

Source files
------------

// File: rtl/grf_write_arbiter.sv
// Write-port arbiter for the general register file: pipeline writeback always wins,
// secondary-unit writes are queued and drained in idle pipeline slots.
module grf_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p_we,
  input  logic [4:0]              p_addr,
  input  logic [31:0]             p_data,
  input  logic [31:0]             p_pc,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [4:0]              s_addr,
  input  logic [31:0]             s_data,
  input  logic [31:0]             s_pc,
  input  logic [4:0]              q_addr,
  output logic                    q_hit,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    RegWr,
  output logic [4:0]              A3,
  output logic [31:0]             WD,
  output logic [31:0]             now_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] ZERO_C    = CW'(0);
  localparam logic [PW-1:0] PTR_ONE_C = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO_C = PW'(0);

  logic          valid_r [DEPTH];
  logic [4:0]    addr_r  [DEPTH];
  logic [31:0]   data_r  [DEPTH];
  logic [31:0]   pc_r    [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic p_wr_s;
  logic push_s;
  logic pop_s;
  logic hit_s;

  // Handshake and slot selection; s_ready uses the registered count only.
  always_comb begin
    s_ready = !reset && (count_r < DEPTH_C);
    p_wr_s  = p_we && (p_addr != 5'd0);
    push_s  = s_valid && s_ready && (s_addr != 5'd0);
    pop_s   = !p_wr_s && (count_r != ZERO_C);
  end

  // Hazard query over live queue entries; register 0 never reports a hit.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (valid_r[i] && (addr_r[i] == q_addr));
    end
    q_hit = hit_s && (q_addr != 5'd0);
  end

  assign count = count_r;

  // Queue storage: squash older matches, pop head, push tail (push wins over squash).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        addr_r[i]  <= 5'd0;
        data_r[i]  <= 32'd0;
        pc_r[i]    <= 32'd0;
      end
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= ZERO_C;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (p_wr_s && (addr_r[i] == p_addr)) begin
          valid_r[i] <= 1'b0;
        end
      end
      // Popped slots are cleared so stale entries never raise q_hit.
      if (pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_ONE_C;
      end
      if (push_s) begin
        valid_r[wr_ptr_r] <= 1'b1;
        addr_r[wr_ptr_r]  <= s_addr;
        data_r[wr_ptr_r]  <= s_data;
        pc_r[wr_ptr_r]    <= s_pc;
        wr_ptr_r          <= wr_ptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered GRF write port; a squashed head drains with RegWr low.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWr  <= 1'b0;
      A3     <= 5'd0;
      WD     <= 32'd0;
      now_pc <= 32'd0;
    end else if (p_wr_s) begin
      RegWr  <= 1'b1;
      A3     <= p_addr;
      WD     <= p_data;
      now_pc <= p_pc;
    end else if (pop_s) begin
      RegWr  <= valid_r[rd_ptr_r];
      A3     <= addr_r[rd_ptr_r];
      WD     <= data_r[rd_ptr_r];
      now_pc <= pc_r[rd_ptr_r];
    end else begin
      RegWr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: directed vector table, hand sequences for fill/reset,
// and random traffic against a queue-based reference model.
module tb_grf_write_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic [31:0] p_pc;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic [31:0] s_pc;
  logic [4:0]  q_addr;
  logic        q_hit;
  logic [2:0]  count;
  logic        RegWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [31:0] now_pc;

  grf_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data), .s_pc(s_pc),
    .q_addr(q_addr), .q_hit(q_hit), .count(count),
    .RegWr(RegWr), .A3(A3), .WD(WD), .now_pc(now_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic [31:0] p_pc;
    logic        s_valid;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [4:0]  q_addr;
    logic        e_ready;
    logic [2:0]  e_count;
    logic        e_hit;
    logic        e_regwr;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an ordered list of pending writes plus the last port values.
  ent_t        mq[$];
  logic        m_regwr = 1'b0;
  logic [4:0]  m_a3 = 5'd0;
  logic [31:0] m_wd = 32'd0;
  logic [31:0] m_pc = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_cycle(input vec_t v, input bit use_exp, input bit chk_pre);
    bit   rdy;
    bit   hit;
    bit   pwr;
    ent_t h;
    ent_t e;
    reset   = v.rst;
    p_we    = v.p_we;
    p_addr  = v.p_addr;
    p_data  = v.p_data;
    p_pc    = v.p_pc;
    s_valid = v.s_valid;
    s_addr  = v.s_addr;
    s_data  = v.s_data;
    s_pc    = v.s_data ^ 32'hC000_0000;
    q_addr  = v.q_addr;
    #1;
    rdy = !v.rst && (mq.size() < DEPTH);
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].valid && mq[i].addr == v.q_addr && v.q_addr != 5'd0) hit = 1'b1;
    if (chk_pre) begin
      chk("s_ready_model", {31'd0, s_ready}, {31'd0, rdy});
      chk("q_hit_model", {31'd0, q_hit}, {31'd0, hit});
      chk("count_model", {29'd0, count}, mq.size());
      if (use_exp) begin
        chk("s_ready_vec", {31'd0, s_ready}, {31'd0, v.e_ready});
        chk("q_hit_vec", {31'd0, q_hit}, {31'd0, v.e_hit});
        chk("count_vec", {29'd0, count}, {29'd0, v.e_count});
      end
    end
    @(posedge clk);
    if (v.rst) begin
      mq.delete();
      m_regwr = 1'b0; m_a3 = 5'd0; m_wd = 32'd0; m_pc = 32'd0;
    end else begin
      pwr = v.p_we && (v.p_addr != 5'd0);
      if (pwr) begin
        m_regwr = 1'b1; m_a3 = v.p_addr; m_wd = v.p_data; m_pc = v.p_pc;
        foreach (mq[i]) if (mq[i].addr == v.p_addr) mq[i].valid = 1'b0;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        m_regwr = h.valid; m_a3 = h.addr; m_wd = h.data; m_pc = h.pc;
      end else begin
        m_regwr = 1'b0;
      end
      if (v.s_valid && rdy && v.s_addr != 5'd0) begin
        e.valid = 1'b1; e.addr = v.s_addr; e.data = v.s_data; e.pc = v.s_data ^ 32'hC000_0000;
        mq.push_back(e);
      end
    end
    #1;
    if (chk_pre) begin
      chk("RegWr_model", {31'd0, RegWr}, {31'd0, m_regwr});
      chk("A3_model", {27'd0, A3}, {27'd0, m_a3});
      chk("WD_model", WD, m_wd);
      chk("now_pc_model", now_pc, m_pc);
      if (use_exp) begin
        chk("RegWr_vec", {31'd0, RegWr}, {31'd0, v.e_regwr});
        chk("A3_vec", {27'd0, A3}, {27'd0, v.e_a3});
        chk("WD_vec", WD, v.e_wd);
      end
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic pwe, input logic [4:0] pa,
                              input logic [31:0] pd, input logic sv, input logic [4:0] sa,
                              input logic [31:0] sd, input logic [4:0] qa);
    vec_t v;
    v = '{rst, pwe, pa, pd, 32'h0000_7000 + pd, sv, sa, sd, qa,
          1'b0, 3'd0, 1'b0, 1'b0, 5'd0, 32'd0};
    return v;
  endfunction

  vec_t tbl [13];
  vec_t v;

  initial begin
    // rst p_we p_addr p_data p_pc s_valid s_addr s_data q_addr | ready count hit | regwr a3 wd
    tbl[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd0,  32'h0,    5'd0,  1'b0, 3'd0, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd5,  32'h1234, 32'h3000, 1'b0, 5'd0,  32'h0,    5'd0,  1'b1, 3'd0, 1'b0, 1'b1, 5'd5,  32'h1234};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd0,  32'h0,    5'd0,  1'b1, 3'd0, 1'b0, 1'b0, 5'd5,  32'h1234};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd8,  32'hAAAA, 5'd0,  1'b1, 3'd0, 1'b0, 1'b0, 5'd5,  32'h1234};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd0,  32'h0,    5'd8,  1'b1, 3'd1, 1'b1, 1'b1, 5'd8,  32'hAAAA};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd0,  32'h0,    5'd8,  1'b1, 3'd0, 1'b0, 1'b0, 5'd8,  32'hAAAA};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,    1'b1, 5'd9,  32'h9999, 5'd9,  1'b1, 3'd0, 1'b0, 1'b0, 5'd8,  32'hAAAA};
    tbl[7]  = '{1'b0, 1'b1, 5'd9,  32'h0909, 32'h3200, 1'b0, 5'd0,  32'h0,    5'd9,  1'b1, 3'd1, 1'b1, 1'b1, 5'd9,  32'h0909};
    tbl[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd0,  32'h0,    5'd9,  1'b1, 3'd1, 1'b0, 1'b0, 5'd9,  32'h9999};
    tbl[9]  = '{1'b0, 1'b1, 5'd10, 32'h0A0A, 32'h3300, 1'b1, 5'd10, 32'hB0B0, 5'd10, 1'b1, 3'd0, 1'b0, 1'b1, 5'd10, 32'h0A0A};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd0,  32'h0,    5'd10, 1'b1, 3'd1, 1'b1, 1'b1, 5'd10, 32'hB0B0};
    tbl[11] = '{1'b0, 1'b1, 5'd0,  32'h1111, 32'h3400, 1'b1, 5'd0,  32'h2222, 5'd0,  1'b1, 3'd0, 1'b0, 1'b0, 5'd10, 32'hB0B0};
    tbl[12] = '{1'b0, 1'b0, 5'd0,  32'h0,    32'h0,    1'b0, 5'd0,  32'h0,    5'd0,  1'b1, 3'd0, 1'b0, 1'b0, 5'd10, 32'hB0B0};

    // Bring the DUT out of its unknown power-up state before any checking.
    run_cycle(tbl[0], 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) run_cycle(tbl[i], 1'b1, 1'b1);
    chk("now_pc_after_p5", now_pc, m_pc);

    // Fill: pipeline holds reg 3 busy while five secondary writes are offered.
    for (int k = 0; k < 5; k++) begin
      run_cycle(mk(1'b0, 1'b1, 5'd3, 32'h300 + k, 1'b1, 5'(11 + k), 32'h100 + k, 5'd0), 1'b0, 1'b1);
      chk("fill_count", {29'd0, count}, (k < 4) ? k + 1 : 4);
    end
    chk("fill_ready_low", {31'd0, s_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      run_cycle(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0), 1'b0, 1'b1);
      chk("drain_regwr", {31'd0, RegWr}, 32'd1);
      chk("drain_a3", {27'd0, A3}, 11 + k);
      chk("drain_wd", WD, 32'h100 + k);
    end
    run_cycle(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0), 1'b0, 1'b1);
    chk("drain_done_regwr", {31'd0, RegWr}, 32'd0);
    chk("drain_done_count", {29'd0, count}, 32'd0);

    // Reset with three entries queued: nothing queued may ever reach the port.
    for (int k = 0; k < 3; k++)
      run_cycle(mk(1'b0, 1'b1, 5'd3, 32'h55, 1'b1, 5'(20 + k), 32'hD00 + k, 5'd0), 1'b0, 1'b1);
    chk("preq_count", {29'd0, count}, 32'd3);
    run_cycle(mk(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h88, 5'd0), 1'b0, 1'b1);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_regwr", {31'd0, RegWr}, 32'd0);
    chk("rst_a3", {27'd0, A3}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      run_cycle(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd21), 1'b0, 1'b1);
      chk("post_rst_regwr", {31'd0, RegWr}, 32'd0);
    end

    // Random traffic over a narrow register range to provoke squashes and hits.
    for (int n = 0; n < 400; n++) begin
      v = mk(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)));
      run_cycle(v, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
